// File: rtl/joy2quad_multi.sv
// Multi-channel joystick-to-quadrature steering emulator with per-bit input synchronisers.
// Define JOY2QUAD_ACCEL_EN to enable hold-to-accelerate step rates (speed port tied to 0 otherwise).
module joy2quad_multi #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned ACCEL_STEPS = 3,
  parameter int unsigned ACCEL_HOLD  = 8
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic [CHANNELS-1:0]   right,
  input  logic [CHANNELS-1:0]   left,
  output logic [2*CHANNELS-1:0] steer,
  output logic [2*CHANNELS-1:0] speed
);

  typedef enum logic [1:0] {DIR_IDLE, DIR_RIGHT, DIR_LEFT} dir_e;

  logic [CHANNELS-1:0] r_s1_q, r_s2_q, l_s1_q, l_s2_q;

  // Phase is stored directly in Gray form so steer comes straight off a flop.
  logic [1:0]       ab_q   [CHANNELS];
  logic [1:0]       ab_d   [CHANNELS];
  logic [DIV_W-1:0] cnt_q  [CHANNELS];
  logic [DIV_W-1:0] cnt_d  [CHANNELS];
  dir_e             last_q [CHANNELS];
  dir_e             last_d [CHANNELS];

`ifdef JOY2QUAD_ACCEL_EN
  localparam int unsigned HOLD_W  = $clog2(ACCEL_HOLD + 1);
  localparam logic [1:0]  SPD_MAX = 2'(ACCEL_STEPS - 1);

  logic [1:0]        spd_q  [CHANNELS];
  logic [1:0]        spd_d  [CHANNELS];
  logic [HOLD_W-1:0] hold_q [CHANNELS];
  logic [HOLD_W-1:0] hold_d [CHANNELS];
`endif

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_q <= '0;
      r_s2_q <= '0;
      l_s1_q <= '0;
      l_s2_q <= '0;
    end else begin
      r_s1_q <= right;
      r_s2_q <= r_s1_q;
      l_s1_q <= left;
      l_s2_q <= l_s1_q;
    end
  end

  always_comb begin
    logic [DIV_W-1:0] per;
    logic [DIV_W-1:0] per0;
    dir_e             dir;
    logic [1:0]       pidx;
    logic [1:0]       pnx;
    logic [1:0]       ab_nx;
    per   = '0;
    per0  = '0;
    dir   = DIR_IDLE;
    pidx  = '0;
    pnx   = '0;
    ab_nx = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      ab_d[ch]   = ab_q[ch];
      cnt_d[ch]  = cnt_q[ch];
      last_d[ch] = last_q[ch];
`ifdef JOY2QUAD_ACCEL_EN
      spd_d[ch]  = spd_q[ch];
      hold_d[ch] = hold_q[ch];
`endif
      if (r_s2_q[ch] && !l_s2_q[ch])
        dir = DIR_RIGHT;
      else if (l_s2_q[ch] && !r_s2_q[ch])
        dir = DIR_LEFT;
      else
        dir = DIR_IDLE;

      per0 = (clkdiv == '0) ? DIV_W'(1) : clkdiv;
`ifdef JOY2QUAD_ACCEL_EN
      per = clkdiv >> spd_q[ch];
      if (per == '0)
        per = DIV_W'(1);
`else
      per = per0;
`endif

      pidx  = {ab_q[ch][1], ^ab_q[ch]};
      pnx   = (dir == DIR_LEFT) ? pidx - 2'd1 : pidx + 2'd1;
      ab_nx = {pnx[1], ^pnx};

      last_d[ch] = dir;
      if (dir == DIR_IDLE) begin
        cnt_d[ch] = '0;
`ifdef JOY2QUAD_ACCEL_EN
        spd_d[ch]  = '0;
        hold_d[ch] = '0;
`endif
      end else if (last_q[ch] != DIR_IDLE && last_q[ch] != dir) begin
        // Reversal: step at once and restart the cadence at base speed.
        ab_d[ch]  = ab_nx;
        cnt_d[ch] = per0 - DIV_W'(1);
`ifdef JOY2QUAD_ACCEL_EN
        spd_d[ch]  = '0;
        hold_d[ch] = '0;
`endif
      end else if (cnt_q[ch] == '0) begin
        ab_d[ch]  = ab_nx;
        cnt_d[ch] = per - DIV_W'(1);
`ifdef JOY2QUAD_ACCEL_EN
        if (32'(hold_q[ch]) + 32'd1 >= ACCEL_HOLD) begin
          if (spd_q[ch] < SPD_MAX) begin
            spd_d[ch]  = spd_q[ch] + 2'd1;
            hold_d[ch] = '0;
          end else begin
            hold_d[ch] = HOLD_W'(ACCEL_HOLD);
          end
        end else begin
          hold_d[ch] = hold_q[ch] + HOLD_W'(1);
        end
`endif
      end else begin
        cnt_d[ch] = cnt_q[ch] - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        ab_q[ch]   <= '0;
        cnt_q[ch]  <= '0;
        last_q[ch] <= DIR_IDLE;
`ifdef JOY2QUAD_ACCEL_EN
        spd_q[ch]  <= '0;
        hold_q[ch] <= '0;
`endif
      end
    end else begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
        ab_q[ch]   <= ab_d[ch];
        cnt_q[ch]  <= cnt_d[ch];
        last_q[ch] <= last_d[ch];
`ifdef JOY2QUAD_ACCEL_EN
        spd_q[ch]  <= spd_d[ch];
        hold_q[ch] <= hold_d[ch];
`endif
      end
    end
  end

  always_comb begin
    steer = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++)
      steer[2*ch +: 2] = ab_q[ch];
  end

`ifdef JOY2QUAD_ACCEL_EN
  always_comb begin
    speed = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++)
      speed[2*ch +: 2] = spd_q[ch];
  end
`else
  assign speed = '0;
`endif

endmodule
